// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory access unit.
// Op codes, FSM state encoding and access-size decode live here.
package mips_mem_pkg;

   typedef enum logic [3:0] {
      LB  = 4'd0,
      LBU = 4'd1,
      LH  = 4'd2,
      LHU = 4'd3,
      LW  = 4'd4,
      SB  = 4'd5,
      SH  = 4'd6,
      SW  = 4'd7
   } mem_op_t;

   typedef logic [1:0] acc_state_t;
   localparam acc_state_t IDLE  = 2'd0;
   localparam acc_state_t ISSUE = 2'd1;
   localparam acc_state_t WAIT  = 2'd2;
   localparam acc_state_t DONE  = 2'd3;

   localparam logic [2:0] SIZE_NONE = 3'd0;
   localparam logic [2:0] SIZE_BYTE = 3'd1;
   localparam logic [2:0] SIZE_HALF = 3'd2;
   localparam logic [2:0] SIZE_WORD = 3'd4;

   function automatic logic is_load(input logic [3:0] op);
      return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   // Illegal codes map to SIZE_NONE so they can never look misaligned.
   function automatic logic [2:0] op_size(input logic [3:0] op);
      logic [2:0] sz;
      case (op)
         LB, LBU, SB: sz = SIZE_BYTE;
         LH, LHU, SH: sz = SIZE_HALF;
         LW, SW:      sz = SIZE_WORD;
         default:     sz = SIZE_NONE;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mips_load_extract.sv
// Lane select and sign/zero extension of a read word.
// Byte at memory offset k arrives on rdata[31-8k -: 8].
module mips_load_extract
   import mips_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [3:0]  op,
   output logic [31:0] result
);

   logic [3:0][7:0] lane;
   logic [1:0]      hi_off;
   logic [7:0]      sel_b;
   logic [15:0]     sel_h;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         lane[k] = rdata[31-8*k -: 8];
      end
      hi_off = offset + 2'd1;
      sel_b  = lane[offset];
      sel_h  = {lane[hi_off], lane[offset]};
      case (op)
         LB:      result = {{24{sel_b[7]}}, sel_b};
         LBU:     result = {24'h0, sel_b};
         LH:      result = {{16{sel_h[15]}}, sel_h};
         LHU:     result = {16'h0, sel_h};
         LW:      result = {lane[3], lane[2], lane[1], lane[0]};
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/mips_mem_access_unit.sv
// CPU-side load/store initiator for the byte-addressed data memory.
// One request at a time: IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE.
module mips_mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        ready,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        mem_active,
   output logic [31:0] mem_addr,
   output logic        mem_wr_en,
   output logic        mem_read_en,
   output logic [3:0]  mem_byte_en,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   acc_state_t  state;
   logic [3:0]  lat_op;
   logic [1:0]  lat_off;

   logic [2:0]  req_size;
   logic [1:0]  eff_off;
   logic        legal;
   logic        bad_align;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] ext_data;

   // Request decode: offset, alignment and the store-lane image.
   // Replicating the source bytes puts them on the right lanes for any legal offset.
   always_comb begin
      req_size  = op_size(op);
      legal     = is_load(op) | is_store(op);
      eff_off   = addr[1:0];
      bad_align = 1'b0;
      if (CHECK_ALIGN) begin
         bad_align = ((req_size == SIZE_HALF) && addr[0]) ||
                     ((req_size == SIZE_WORD) && (addr[1:0] != 2'b00));
      end else if (req_size == SIZE_HALF) begin
         eff_off = {addr[1], 1'b0};
      end else if (req_size == SIZE_WORD) begin
         eff_off = 2'b00;
      end
      case (req_size)
         SIZE_BYTE: begin
            req_be    = 4'b0001 << eff_off;
            req_wdata = {4{store_data[7:0]}};
         end
         SIZE_HALF: begin
            req_be    = 4'b0011 << eff_off;
            req_wdata = {2{store_data[15:0]}};
         end
         SIZE_WORD: begin
            req_be    = 4'b1111;
            req_wdata = store_data;
         end
         default: begin
            req_be    = 4'b0000;
            req_wdata = 32'h0;
         end
      endcase
   end

   mips_load_extract u_extract (
      .rdata  (mem_rdata),
      .offset (lat_off),
      .op     (lat_op),
      .result (ext_data)
   );

   assign ready = (state == IDLE);
   assign done  = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lat_op      <= 4'h0;
         lat_off     <= 2'b00;
         load_data   <= 32'h0;
         misaligned  <= 1'b0;
         mem_active  <= 1'b0;
         mem_addr    <= 32'h0;
         mem_wr_en   <= 1'b0;
         mem_read_en <= 1'b0;
         mem_byte_en <= 4'h0;
         mem_wdata   <= 32'h0;
      end else begin
         mem_active  <= 1'b1;
         mem_wr_en   <= 1'b0;
         mem_read_en <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (!legal) begin
                     misaligned <= 1'b0;
                     state      <= DONE;
                  end else if (bad_align) begin
                     misaligned <= 1'b1;
                     state      <= DONE;
                  end else begin
                     misaligned  <= 1'b0;
                     lat_op      <= op;
                     lat_off     <= eff_off;
                     mem_addr    <= {addr[31:2], 2'b00};
                     mem_byte_en <= req_be;
                     if (is_store(op)) begin
                        mem_wr_en <= 1'b1;
                        mem_wdata <= req_wdata;
                     end else begin
                        mem_read_en <= 1'b1;
                     end
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_byte_en <= 4'h0;
               state       <= is_store(lat_op) ? DONE : WAIT;
            end
            WAIT: begin
               load_data <= ext_data;
               state     <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Directed + random bench for mips_mem_access_unit against a byte-array memory model.
// Expected results come from a separate reference byte image updated by op semantics.
module tb_mips_mem_access_unit;
   import mips_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  op = 4'h0;
   logic [31:0] addr = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic        ready, done, misaligned, mem_active;
   logic        mem_wr_en, mem_read_en;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_rdata = 32'h0;

   logic [7:0]  dev_mem [0:1023];
   logic [7:0]  ref_mem [0:1023];
   int          errs = 0;
   int          checks = 0;
   logic [31:0] last_load = 32'h0;

   mips_mem_access_unit #(.CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
      .store_data(store_data), .ready(ready), .done(done),
      .load_data(load_data), .misaligned(misaligned), .mem_active(mem_active),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
      .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Registered memory device driven by the DUT strobes.
   always @(posedge clk) begin
      if (mem_wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_byte_en[k]) dev_mem[{mem_addr[9:2], 2'(k)}] <= mem_wdata[8*k +: 8];
         end
      end
      if (mem_read_en) begin
         mem_rdata <= {dev_mem[{mem_addr[9:2], 2'd0}], dev_mem[{mem_addr[9:2], 2'd1}],
                       dev_mem[{mem_addr[9:2], 2'd2}], dev_mem[{mem_addr[9:2], 2'd3}]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d, input bit hold);
      int sz, lat, n, wr, rd;
      bit ld, st, legal, mis, seen;
      logic [1:0]  off;
      logic [3:0]  ebe;
      logic [31:0] ewd, emask, eld, v;
      ld    = (o == LB) || (o == LBU) || (o == LH) || (o == LHU) || (o == LW);
      st    = (o == SB) || (o == SH) || (o == SW);
      legal = ld | st;
      sz    = (o == LB || o == LBU || o == SB) ? 1 :
              (o == LH || o == LHU || o == SH) ? 2 : (legal ? 4 : 0);
      off   = a[1:0];
      mis   = (sz == 2 && a[0]) || (sz == 4 && off != 2'b00);
      ebe = 4'h0; ewd = 32'h0; emask = 32'h0; v = 32'h0;
      for (int i = 0; i < sz; i++) begin
         ebe[int'(off) + i] = 1'b1;
         ewd[8*(int'(off) + i) +: 8]   = d[8*i +: 8];
         emask[8*(int'(off) + i) +: 8] = 8'hFF;
         v[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
      end
      if (o == LB && v[7])  v = v | 32'hFFFF_FF00;
      if (o == LH && v[15]) v = v | 32'hFFFF_0000;
      if (!legal || mis) begin lat = 1; eld = last_load; end
      else if (st)       begin lat = 2; eld = last_load; end
      else               begin lat = 3; eld = v; end

      chk("ready_idle", 32'(ready), 32'd1);
      req = 1'b1; op = o; addr = a; store_data = d;
      wr = 0; rd = 0; seen = 0; n = 0;
      while (!seen && n < 6) begin
         @(negedge clk);
         n++;
         if (!hold) req = 1'b0;
         chk("no_overlap", 32'(mem_wr_en & mem_read_en), 32'd0);
         if (mem_wr_en) begin
            wr++;
            chk("st_addr", mem_addr, {a[31:2], 2'b00});
            chk("st_byte_en", 32'(mem_byte_en), 32'(ebe));
            chk("st_wdata", mem_wdata & emask, ewd);
         end
         if (mem_read_en) begin
            rd++;
            chk("ld_addr", mem_addr, {a[31:2], 2'b00});
         end
         if (done) begin
            seen = 1;
            chk("latency", 32'(n), 32'(lat));
            chk("misaligned", 32'(misaligned), 32'(legal && mis));
            chk("load_data", load_data, eld);
            chk("ready_in_done", 32'(ready), 32'd0);
            chk("wr_strobes", 32'(wr), 32'(st && !mis));
            chk("rd_strobes", 32'(rd), 32'(ld && !mis));
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      if (st && !mis) begin
         for (int i = 0; i < sz; i++) ref_mem[int'(a[9:0]) + int'(off) - int'(off) + i] = d[8*i +: 8];
      end
      last_load = eld;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      int dn;
      logic [31:0] r;
      for (int i = 0; i < 1024; i++) begin
         r = $urandom();
         dev_mem[i] = r[7:0];
         ref_mem[i] = r[7:0];
      end
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_strobes", {26'h0, mem_wr_en, mem_read_en, mem_byte_en}, 32'h0);
      chk("rst_active", 32'(mem_active), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("active_after_rst", 32'(mem_active), 32'd1);

      run(SW, 32'h0000_0404, 32'hDEAD_BEEF, 1'b0);
      run(LW, 32'h0000_0404, 32'h0, 1'b0);
      chk("spec_lw", load_data, 32'hDEAD_BEEF);
      run(SB, 32'h0000_0409, 32'h0000_0080, 1'b0);
      run(LB, 32'h0000_0409, 32'h0, 1'b0);
      chk("spec_lb", load_data, 32'hFFFF_FF80);
      run(LBU, 32'h0000_0409, 32'h0, 1'b0);
      chk("spec_lbu", load_data, 32'h0000_0080);
      run(SH, 32'h0000_040E, 32'h0000_8001, 1'b0);
      run(LH, 32'h0000_040E, 32'h0, 1'b0);
      chk("spec_lh", load_data, 32'hFFFF_8001);
      run(LHU, 32'h0000_040E, 32'h0, 1'b0);
      chk("spec_lhu", load_data, 32'h0000_8001);
      run(LW, 32'h0000_0402, 32'h0, 1'b0);
      run(SH, 32'h0000_0401, 32'h1234, 1'b0);
      chk("mis_keeps_load", load_data, 32'h0000_8001);
      run(4'hA, 32'h0000_0400, 32'h0, 1'b0);
      // Held request: accepted once, re-accepted only after done.
      run(LW, 32'h0000_0404, 32'h0, 1'b1);
      run(LW, 32'h0000_0404, 32'h0, 1'b0);

      // Reset during WAIT of a load.
      op = LW; addr = 32'h0000_0404; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("pre_rst_read_en", 32'(mem_read_en), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_wait_strobes", {30'h0, mem_wr_en, mem_read_en}, 32'h0);
      chk("rst_wait_ready", 32'(ready), 32'd1);
      chk("rst_wait_done", 32'(done), 32'd0);
      chk("rst_wait_load", load_data, 32'h0);
      chk("rst_wait_addr", mem_addr, 32'h0);
      last_load = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      dn = 0;
      repeat (4) begin
         @(negedge clk);
         dn += int'(done);
      end
      chk("rst_no_done", 32'(dn), 32'd0);

      // Reset during ISSUE of a store: the write strobe must drop at once.
      op = SW; addr = 32'h0000_0410; store_data = 32'h5555_AAAA; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("pre_rst_wr_en", 32'(mem_wr_en), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_issue_wr_en", 32'(mem_wr_en), 32'd0);
      chk("rst_issue_be", 32'(mem_byte_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run(LW, 32'h0000_0410, 32'h0, 1'b0);
      run(LW, 32'h0000_0404, 32'h0, 1'b0);
      chk("post_rst_lw", load_data, 32'hDEAD_BEEF);

      for (int t = 0; t < 80; t++) begin
         r = $urandom();
         run(4'($urandom_range(0, 9)), {r[31:10], 4'h1, 6'($urandom_range(0, 63))}, $urandom(), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
